// File: rtl/ex_mdu.sv
// E-stage multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU are treated as no-ops.
module ex_mdu #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Counter is sized for the longer of the two busy periods.
  localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   sh_hi;
  logic [31:0]   sh_lo;
  logic          sh_wr;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [63:0]   mul_res;

  assign busy = (state == RUN);

  always_comb begin
    prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u  = {32'd0, a} * {32'd0, b};
    mul_res = md_op[0] ? prod_u : prod_s;
  end

`ifdef MDU_DIV_EN
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

  logic        sgn;
  logic [31:0] am;
  logic [31:0] bm;
  logic [31:0] bd;
  logic [31:0] qm;
  logic [31:0] rm;
  logic [31:0] quo;
  logic [31:0] rem;

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
  always_comb begin
    sgn = ~md_op[0];
    am  = (sgn && a[31]) ? -a : a;
    bm  = (sgn && b[31]) ? -b : b;
    bd  = (bm == '0) ? 32'd1 : bm;
    qm  = am / bd;
    rm  = am % bd;
    quo = (sgn && (a[31] ^ b[31])) ? -qm : qm;
    rem = (sgn && a[31]) ? -rm : rm;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      sh_hi <= '0;
      sh_lo <= '0;
      sh_wr <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (md_op)
              3'd0, 3'd1: begin
                sh_hi <= mul_res[63:32];
                sh_lo <= mul_res[31:0];
                sh_wr <= 1'b1;
                cnt   <= MUL_N;
                state <= RUN;
              end
`ifdef MDU_DIV_EN
              3'd2, 3'd3: begin
                sh_hi <= rem;
                sh_lo <= quo;
                sh_wr <= (b != '0);
                cnt   <= DIV_N;
                state <= RUN;
              end
`endif
              3'd4: hi <= a;
              3'd5: lo <= a;
              default: ;
            endcase
          end
        end
        default: begin
          if (cnt == CW'(1)) begin
            if (sh_wr) begin
              hi <= sh_hi;
              lo <= sh_lo;
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: stimulus queues per-cycle expectations, a negedge monitor checks them.
// Expectations for DIV/DIVU follow MDU_DIV_EN the same way the design build does.
module tb_ex_mdu;

  localparam int unsigned MN = 5;
  localparam int unsigned DN = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  ex_mdu #(.MUL_CYCLES(MN), .DIV_CYCLES(DN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mh = '0;
  logic [31:0] ml = '0;

  task automatic push(input int unsigned due, input logic bz, input logic [31:0] eh,
                      input logic [31:0] el, input string name);
    exp_t x;
    int i;
    x.due = due; x.busy = bz; x.hi = eh; x.lo = el; x.name = name;
    i = sb.size();
    while (i > 0 && sb[i-1].due > due) i--;
    sb.insert(i, x);
  endtask

  // Monitor: everything due by this cycle is compared against the registered outputs.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.due != cyc || busy !== e.busy || hi !== e.hi || lo !== e.lo) begin
        errors++;
        $display("FAIL %s cyc=%0d due=%0d: got busy=%b hi=%h lo=%h, want busy=%b hi=%h lo=%h",
                 e.name, cyc, e.due, busy, hi, lo, e.busy, e.hi, e.lo);
      end
    end
  end

  // Called at a negedge; issues at the next edge k and returns at the negedge after edge k+n.
  task automatic go(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                    input int unsigned n, input logic [31:0] eh, input logic [31:0] el,
                    input bit inject, input string name);
    int unsigned k;
    k = cyc + 1;
    for (int unsigned d = 0; d < n; d++) push(k + d, 1'b1, mh, ml, {name, "_busy"});
    if (n == 0 && op == 3'd4) push(k, 1'b0, eh, ml, name);
    else push(k + n, 1'b0, eh, el, name);
    start = 1'b1; md_op = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    if (inject && n > 1) begin
      start = 1'b1; md_op = 3'd3; a = 32'd7; b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (n - 1) @(negedge clk);
    end else begin
      repeat (n) @(negedge clk);
    end
    mh = eh;
    ml = el;
  endtask

  initial begin
    int unsigned k;
    repeat (2) @(negedge clk);
    push(cyc + 1, 1'b0, '0, '0, "reset_low");
    @(negedge clk);
    #1 reset_n = 1'b1;
    push(cyc + 1, 1'b0, '0, '0, "reset_rel");
    @(negedge clk);

    go(3'd0, 32'hFFFFFFFF, 32'd2, MN, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mult_neg");
    go(3'd1, 32'hFFFFFFFF, 32'd2, MN, 32'h00000001, 32'hFFFFFFFE, 1, "multu_ign");
`ifdef MDU_DIV_EN
    go(3'd2, 32'hFFFFFFF9, 32'd2, DN, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, "div_neg");
    go(3'd3, 32'd7, 32'd0, DN, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, "divu_zero");
    go(3'd2, 32'h80000000, 32'hFFFFFFFF, DN, 32'h00000000, 32'h80000000, 0, "div_ovf");
`else
    go(3'd2, 32'hFFFFFFF9, 32'd2, 0, mh, ml, 0, "div_off");
    go(3'd3, 32'd7, 32'd0, 0, mh, ml, 0, "divu_off");
`endif
    go(3'd4, 32'h12345678, 32'h0, 0, 32'h12345678, ml, 0, "mthi");
    go(3'd5, 32'h9ABCDEF0, 32'h0, 0, 32'h12345678, 32'h9ABCDEF0, 0, "mtlo");
    go(3'd6, 32'hDEADBEEF, 32'h1, 0, mh, ml, 0, "reserved");
`ifdef MDU_DIV_EN
    go(3'd2, 32'd8, 32'd2, DN, 32'h0, 32'h4, 0, "div_8_2");
`else
    go(3'd2, 32'd8, 32'd2, 0, mh, ml, 0, "div_8_2_off");
`endif
    go(3'd0, 32'd3, 32'd4, MN, 32'h0, 32'd12, 0, "mult_3_4");

    // Reset in the third busy cycle: result must be discarded, no later commit.
    k = cyc + 1;
    for (int unsigned d = 0; d < 3; d++) push(k + d, 1'b1, mh, ml, "rst_busy");
    push(k + 3, 1'b0, '0, '0, "rst_mid");
    for (int unsigned d = 4; d < 8; d++) push(k + d, 1'b0, '0, '0, "no_commit");
    start = 1'b1; md_op = 3'd0; a = 32'd5; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (6) @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending expectations, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
